// File: rtl/pcihellocore_led_pkg.sv
// Shared definitions for the LED fader: level range, FSM states, gamma table and PWM width.
// LED_FADER_GAMMA_EN selects an 8-bit gamma-corrected PWM counter instead of linear duty.
package pcihellocore_led_pkg;

    typedef enum logic {
        IDLE,
        FADING
    } fader_state_t;

    // Perceptual brightness curve indexed by a 4-bit level; ends pinned at 0 and 255.
    localparam logic [7:0] GAMMA_LUT [16] = '{
        8'd0,   8'd1,   8'd3,   8'd7,   8'd14,  8'd23,  8'd34,  8'd47,
        8'd64,  8'd84,  8'd105, 8'd131, 8'd160, 8'd192, 8'd223, 8'd255
    };

    function automatic int level_max(input int level_w);
        return (1 << level_w) - 1;
    endfunction

    function automatic int pwm_width(input int level_w);
`ifdef LED_FADER_GAMMA_EN
        return (level_w > 0) ? 8 : 8;
`else
        return level_w;
`endif
    endfunction

endpackage

// File: rtl/pcihellocore_led_tick_gen.sv
// Timebase for the LED fader: prescaler tick, free-running PWM counter and fade step pulse.
module pcihellocore_led_tick_gen #(
    parameter int PRESCALE = 1024,
    parameter int STEP_DIV = 4,
    parameter int PWM_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic [PWM_W-1:0] pwm_cnt,
    output logic             step
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SD_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(STEP_DIV - 1);

    logic [PS_W-1:0] prescaler;
    logic [SD_W-1:0] step_cnt;
    logic            period_end;

    assign tick       = (prescaler == PS_LAST);
    assign period_end = tick && (pwm_cnt == '1);
    assign step       = period_end && (step_cnt == SD_LAST);

    // pwm_cnt wraps naturally at its full width, which is the end of a PWM period.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            step_cnt  <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_end) begin
                step_cnt <= step ? '0 : step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcihellocore_led_fader.sv
// LED fader between the PIO out_port and the LED pins: each channel ramps linearly toward on/off
// and is PWM-driven from a shared counter. Optional gamma duty via LED_FADER_GAMMA_EN.
module pcihellocore_led_fader #(
    parameter int WIDTH    = 32,
    parameter int LEVEL_W  = 4,
    parameter int PRESCALE = 1024,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    import pcihellocore_led_pkg::*;

    localparam int PWM_W = pwm_width(LEVEL_W);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(level_max(LEVEL_W));

`ifdef LED_FADER_GAMMA_EN
    if (LEVEL_W != 4) begin : g_gamma_check
        $error("LED_FADER_GAMMA_EN needs LEVEL_W == 4");
    end
`endif

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] at_goal;
    logic [WIDTH-1:0] led_next;
    logic             tick_unused;
    logic             step;
    logic [PWM_W-1:0] pwm_cnt;
    fader_state_t     state;
    fader_state_t     state_next;

    pcihellocore_led_tick_gen #(
        .PRESCALE (PRESCALE),
        .STEP_DIV (STEP_DIV),
        .PWM_W    (PWM_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick_unused),
        .pwm_cnt (pwm_cnt),
        .step    (step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            target <= '0;
        end else begin
            target <= pattern_in;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [LEVEL_W-1:0] level;
        logic [LEVEL_W-1:0] goal;
        logic [PWM_W-1:0]   duty;

        assign goal       = target[i] ? LEVEL_MAX : '0;
        assign at_goal[i] = (level == goal);
`ifdef LED_FADER_GAMMA_EN
        assign duty = GAMMA_LUT[level];
`else
        assign duty = level;
`endif
        // Full level is forced solid so the top brightness has no off slot.
        assign led_next[i] = (level == LEVEL_MAX) || (duty > pwm_cnt);

        always_ff @(posedge clk) begin
            if (reset) begin
                level <= '0;
            end else if (step && (state == FADING) && !at_goal[i]) begin
                level <= target[i] ? level + 1'b1 : level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
            state   <= IDLE;
        end else begin
            led_out <= led_next;
            state   <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!(&at_goal)) state_next = FADING;
            FADING:  if (&at_goal) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == FADING);

endmodule
